// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types and constants: instruction width, word step, default reset PC.
// Pure declarations; no timing or flow-control behaviour lives here.
package fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] WORD_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: redirect, imem request/response and IF/ID output handshakes.
// master = fetch_queue view; slave = the surrounding memory / pipeline view.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic               redirect_valid;
  logic [INSTR_W-1:0] redirect_pc;
  logic               imem_req_valid;
  logic [INSTR_W-1:0] imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [INSTR_W-1:0] out_pc_plus4;
  logic               out_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// In-order storage queue with flush; write visible at the head one cycle after push.
// No internal backpressure: the caller must never push when full or pop when empty.
module fetch_queue_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  assign do_pop    = pop && !empty;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: credit-limited sequential fetch into a DEPTH-entry queue, flushed on redirect.
// Response-to-out_valid is one cycle; requests stop when queued + in-flight reaches DEPTH.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] resp_pc;
  logic [INSTR_W-1:0] redirect_target;
  logic [CW-1:0]      inflight, inflight_nxt, discard, fifo_count, committed;
  logic               req_fire, push, drop_old, pop;
  logic               fifo_full, fifo_empty;
  fq_entry_t          push_entry, head_entry;

  assign committed       = fifo_count + inflight;
  assign redirect_target = word_align(bus.redirect_pc);

  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (committed < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign drop_old = bus.imem_resp_valid && (discard != '0);
  assign push     = bus.imem_resp_valid && (discard == '0) && !bus.redirect_valid;
  assign pop      = bus.out_valid && bus.out_ready && !bus.redirect_valid;

  // Responses come back in order, so the next kept response always belongs to resp_pc.
  assign push_entry = '{pc: resp_pc, instr: bus.imem_resp_data};

  assign bus.out_valid    = !fifo_empty;
  assign bus.out_instr    = fifo_empty ? '0 : head_entry.instr;
  assign bus.out_pc_plus4 = fifo_empty ? (RESET_PC + WORD_STEP) : (head_entry.pc + WORD_STEP);

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire)            inflight_nxt = inflight_nxt + ONE;
    if (bus.imem_resp_valid) inflight_nxt = inflight_nxt - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (bus.redirect_valid) begin
        // Every request still outstanding after this cycle, old-discard ones included, is stale.
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        discard  <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + WORD_STEP;
        if (push)     resp_pc  <= resp_pc + WORD_STEP;
        if (drop_old) discard  <= discard - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && fifo_full));
    end
  end

  fetch_queue_sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_entry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: epoch-tagged request model plus directed literal checkpoints.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Memory: in-order responses, latency drawn per request, old requests squashed by reset.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    last_due;
  int    lat_min;
  int    lat_max;

  initial begin : memory
    int d;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    cyc      = 0;
    last_due = -1;
    forever begin
      at_neg();
      if (bus.imem_resp_valid && mq.size() > 0) mq.delete(0);
      if (reset) begin
        mq.delete();
        last_due = cyc;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        d = cyc + $urandom_range(lat_min, lat_max);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{addr: bus.imem_req_addr, due: d});
      end
      tick();
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(mq[0].addr);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
      end
    end
  end

  // Reference model: outstanding requests carry the epoch they were issued in;
  // only current-epoch responses reach the queue, which must present consecutive PCs.
  int          outst[$];
  int          epoch      = 0;
  int          mcount     = 0;
  int          total_pops = 0;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] exp_out_pc = RESET_PC;

  always @(negedge clk) begin : model
    logic exp_req, exp_out, redir;
    int   e;
    if (reset) begin
      check1("req_vld_in_reset", bus.imem_req_valid, 1'b0);
      outst.delete();
      mcount     = 0;
      epoch      = epoch + 1;
      exp_req_pc = RESET_PC;
      exp_out_pc = RESET_PC;
    end else begin
      redir   = bus.redirect_valid;
      exp_req = !redir && (mcount + outst.size() < DEPTH);
      exp_out = (mcount > 0);
      check1("req_valid", bus.imem_req_valid, exp_req);
      if (exp_req) check32("req_addr", bus.imem_req_addr, exp_req_pc);
      check1("out_valid", bus.out_valid, exp_out);
      if (exp_out) begin
        check32("out_pc_plus4", bus.out_pc_plus4, exp_out_pc + 32'd4);
        check32("out_instr", bus.out_instr, mem_word(exp_out_pc));
      end
      if (bus.imem_resp_valid) begin
        e = -1;
        if (outst.size() > 0) e = outst.pop_front();
        if (e == epoch && !redir) mcount++;
      end
      if (exp_out && bus.out_ready && !redir) begin
        mcount--;
        total_pops++;
        exp_out_pc = exp_out_pc + 32'd4;
      end
      if (exp_req && bus.imem_req_ready) begin
        outst.push_back(epoch);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redir) begin
        epoch      = epoch + 1;
        mcount     = 0;
        exp_req_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        exp_out_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, k;
    reset               = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b1;
    bus.imem_req_ready  = 1'b1;
    lat_min = 1;
    lat_max = 1;
    repeat (3) tick();

    // Reset release with a one-cycle memory and an always-ready consumer.
    reset = 1'b0;
    at_neg();
    check1 ("rst_req_vld",  bus.imem_req_valid, 1'b1);
    check32("rst_req_addr", bus.imem_req_addr, 32'h0);
    check1 ("rst_out_vld",  bus.out_valid, 1'b0);
    check32("rst_pc4",      bus.out_pc_plus4, 32'h4);
    check32("rst_instr",    bus.out_instr, 32'h0);
    tick(); at_neg();
    check32("seq_addr1", bus.imem_req_addr, 32'h4);
    tick(); at_neg();
    check1 ("first_out_vld", bus.out_valid, 1'b1);
    check32("first_pc4",     bus.out_pc_plus4, 32'h4);
    check32("first_instr",   bus.out_instr, mem_word(32'h0));
    check32("seq_addr2",     bus.imem_req_addr, 32'h8);
    tick(); at_neg();
    check32("second_pc4", bus.out_pc_plus4, 32'h8);
    n = 0;
    repeat (10) begin
      tick(); at_neg();
      if (bus.out_valid && bus.out_ready) n++;
    end
    check32("throughput", n, 32'd10);

    // Mid-stream reset, then a ten-cycle consumer stall.
    tick(); reset = 1'b1; bus.out_ready = 1'b0;
    at_neg();
    check1("rst_blocks_req", bus.imem_req_valid, 1'b0);
    tick(); reset = 1'b0;
    at_neg();
    check1 ("post_rst_out_vld", bus.out_valid, 1'b0);
    check32("post_rst_addr",    bus.imem_req_addr, RESET_PC);
    n = (bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0;
    repeat (9) begin
      tick(); at_neg();
      if (bus.imem_req_valid && bus.imem_req_ready) n++;
    end
    check32("stall_accepts", n, 32'd4);
    check1 ("stall_req_vld", bus.imem_req_valid, 1'b0);
    check1 ("stall_out_vld", bus.out_valid, 1'b1);
    tick(); bus.out_ready = 1'b1;
    at_neg();
    check32("drain_pc4_0", bus.out_pc_plus4, 32'h4);
    tick(); at_neg();
    check32("drain_pc4_1", bus.out_pc_plus4, 32'h8);
    check32("resume_addr", bus.imem_req_addr, 32'h10);

    // Redirect with three requests in flight (latency 4).
    tick(); reset = 1'b1; lat_min = 4; lat_max = 4;
    tick(); reset = 1'b0;
    repeat (3) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    at_neg();
    check1("redir_blocks_req", bus.imem_req_valid, 1'b0);
    tick(); bus.redirect_valid = 1'b0;
    at_neg();
    check32("redir_addr",  bus.imem_req_addr, 32'h100);
    check1 ("redir_flush", bus.out_valid, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick(); at_neg(); k++;
    end
    check32("redir_delay", k, 32'd5);
    check32("redir_pc4",   bus.out_pc_plus4, 32'h104);

    // Redirect (unaligned target) colliding with a response and a ready consumer.
    tick(); reset = 1'b1; lat_min = 2; lat_max = 2;
    tick(); reset = 1'b0;
    repeat (3) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
    at_neg();
    check1("race_resp_vld", bus.imem_resp_valid, 1'b1);
    check1("race_out_vld",  bus.out_valid, 1'b1);
    tick(); bus.redirect_valid = 1'b0;
    at_neg();
    check32("race_addr",  bus.imem_req_addr, 32'h100);
    check1 ("race_flush", bus.out_valid, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick(); at_neg(); k++;
    end
    check32("race_delay", k, 32'd3);
    check32("race_pc4",   bus.out_pc_plus4, 32'h104);
    check32("race_instr", bus.out_instr, mem_word(32'h100));

    // Random traffic: toggling then random memory ready, 1-3 cycle latency.
    tick(); reset = 1'b1; lat_min = 1; lat_max = 3;
    tick(); reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      bus.imem_req_ready = (i < 1000) ? (i % 2 == 0) : ($urandom_range(0, 1) == 1);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc    = ($urandom_range(0, 7) == 0) ?
                           (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      reset              = ($urandom_range(0, 499) == 0);
      tick();
    end
    check1("random_activity", total_pops > 300, 1'b1);

    // PC wrap across 0xFFFF_FFFC.
    reset = 1'b1; lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; bus.redirect_valid = 1'b0;
    tick(); reset = 1'b0;
    repeat (5) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    tick(); bus.redirect_valid = 1'b0;
    at_neg();
    check32("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFF8);
    tick(); at_neg();
    check32("wrap_addr1", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick(); at_neg();
    check32("wrap_addr2", bus.imem_req_addr, 32'h0000_0000);
    check1 ("wrap_out_vld", bus.out_valid, 1'b1);
    check32("wrap_pc4_0",   bus.out_pc_plus4, 32'hFFFF_FFFC);
    tick(); at_neg();
    check32("wrap_pc4_1", bus.out_pc_plus4, 32'h0000_0000);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
